// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multiport register file and its scoreboard.
package rf_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 32;
   localparam int REG_ZERO   = 0;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for RAW hazard detection, with write-clear, issue-set and flush.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR_W   = clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   input  logic                     sb_flush,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_busy
);
   logic [NUM_WR-1:0][ADDR_W-1:0] wa;
   logic [NUM_RD-1:0][ADDR_W-1:0] ra;
   logic [DEPTH-1:0]              busy, busy_nxt;

   assign wa = wr_addr;
   assign ra = rd_addr;

   // Order matters: write-clear, then issue-set (newer producer), then flush.
   always_comb begin
      busy_nxt = busy;
      for (int j = 0; j < NUM_WR; j++)
         if (wr_en[j]) busy_nxt[wa[j]] = 1'b0;
      if (sb_set) busy_nxt[sb_addr] = 1'b1;
      if (sb_flush) busy_nxt = '0;
      if (ZERO_REG != 0) busy_nxt[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic fwd;
      always_comb begin
         fwd = 1'b0;
         for (int j = 0; j < NUM_WR; j++)
            if (BYPASS != 0 && wr_en[j] && wa[j] == ra[i]) fwd = 1'b1;
      end
      assign rd_busy[i] = busy[ra[i]] & ~fwd;
   end
endmodule

// File: rtl/rf_multiport_sb.sv
// Multiport register file with optional write-to-read bypass and a busy scoreboard.
module rf_multiport_sb
   import rf_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int ADDR_W  = clog2(DEPTH)
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   input  logic                     sb_flush
);
   logic [NUM_RD-1:0][ADDR_W-1:0] ra;
   logic [NUM_RD-1:0][DATA_W-1:0] rd;
   logic [NUM_WR-1:0][ADDR_W-1:0] wa;
   logic [NUM_WR-1:0][DATA_W-1:0] wd;
   logic [DEPTH-1:0][DATA_W-1:0]  regs;

   assign ra      = rd_addr;
   assign wa      = wr_addr;
   assign wd      = wr_data;
   assign rd_data = rd;

   // Later ports overwrite earlier ones in the loop, so the highest index wins.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) regs <= '0;
      else
         for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && !(ZERO_REG != 0 && wa[j] == ADDR_W'(REG_ZERO)))
               regs[wa[j]] <= wd[j];

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic              hit;
      logic [DATA_W-1:0] byp, val;
      always_comb begin
         hit = 1'b0;
         byp = '0;
         for (int j = 0; j < NUM_WR; j++)
            if (BYPASS != 0 && wr_en[j] && wa[j] == ra[i]) begin
               hit = 1'b1;
               byp = wd[j];
            end
         // Reset gating keeps a bypassed write from leaking out while rst_n is low.
         if (!rst_n || (ZERO_REG != 0 && ra[i] == ADDR_W'(REG_ZERO))) val = '0;
         else if (hit) val = byp;
         else          val = regs[ra[i]];
      end
      assign rd[i] = val;
   end

   rf_scoreboard #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_sb (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush),
      .rd_addr(rd_addr), .rd_busy(rd_busy)
   );
endmodule

// File: tb/tb_rf_multiport_sb.sv
// Table-driven bench with an expectation queue for rf_multiport_sb (bypass and no-bypass instances).
module tb_rf_multiport_sb;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main instance: 2 write ports, bypass on
   logic [2*AW-1:0] rd_addr;
   logic [63:0]     rd_data;
   logic [1:0]      rd_busy;
   logic [1:0]      wr_en;
   logic [2*AW-1:0] wr_addr;
   logic [63:0]     wr_data;
   logic            sb_set, sb_flush;
   logic [AW-1:0]   sb_addr;

   // second instance: 1 write port, bypass off
   logic [2*AW-1:0] b_rd_addr;
   logic [63:0]     b_rd_data;
   logic [1:0]      b_rd_busy;
   logic [0:0]      b_wr_en;
   logic [AW-1:0]   b_wr_addr;
   logic [31:0]     b_wr_data;
   logic            b_sb_set, b_sb_flush;
   logic [AW-1:0]   b_sb_addr;

   rf_multiport_sb #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) u0 (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush));

   rf_multiport_sb #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)) u1 (
      .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .sb_set(b_sb_set), .sb_addr(b_sb_addr), .sb_flush(b_sb_flush));

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0, wa1, sa, ra0, ra1;
      logic [31:0] wd0, wd1, ed0, ed1;
      logic        set, fl;
      logic [1:0]  eb;
   } vec_t;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   vec_t tbl[$];
   exp_t q[$];
   int checks = 0;
   int errors = 0;

   function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                               logic [4:0] wa1, logic [31:0] wd1, logic set, logic [4:0] sa,
                               logic fl, logic [4:0] ra0, logic [4:0] ra1,
                               logic [31:0] ed0, logic [31:0] ed1, logic [1:0] eb);
      vec_t v;
      v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
      v.set = set; v.sa = sa; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
      v.ed0 = ed0; v.ed1 = ed1; v.eb = eb;
      return v;
   endfunction

   function automatic logic [31:0] act(int sel);
      case (sel)
         0: return rd_data[31:0];
         1: return rd_data[63:32];
         2: return {30'b0, rd_busy};
         3: return b_rd_data[63:32];
         4: return {30'b0, b_rd_busy};
         default: return b_rd_data[31:0];
      endcase
   endfunction

   task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
      exp_t e;
      e.name = name; e.sel = sel; e.exp = exp;
      q.push_back(e);
   endtask

   task automatic check_all();
      exp_t e;
      logic [31:0] a;
      while (q.size() > 0) begin
         e = q.pop_front();
         a = act(e.sel);
         checks++;
         if (a !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", e.name, a, e.exp, $time);
         end
      end
   endtask

   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0;
      sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
      b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
      b_sb_set = 1'b0; b_sb_addr = '0; b_sb_flush = 1'b0;
   endtask

   initial begin
      idle();
      rd_addr = {5'd5, 5'd0};
      b_rd_addr = {5'd7, 5'd7};

      // reset state
      repeat (2) @(negedge clk);
      expect_val("rst_d0", 0, 32'h0);
      expect_val("rst_d1", 1, 32'h0);
      expect_val("rst_busy", 2, 32'h0);
      expect_val("rst_b_busy", 4, 32'h0);
      #2 check_all();
      @(negedge clk) rst_n = 1'b1;

      //             we     wa0  wd0           wa1  wd1    set sa  fl  ra0 ra1 ed0           ed1           eb
      tbl.push_back(mk(2'b01, 7, 32'hA5A5A5A5, 0, 32'h0,  0, 0,  0,  0, 7, 32'h0,        32'hA5A5A5A5, 2'b00));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0,  0,  7, 3, 32'hA5A5A5A5, 32'h0,        2'b00));
      tbl.push_back(mk(2'b11, 3, 32'h11,       3, 32'h22, 0, 0,  0,  3, 7, 32'h22,       32'hA5A5A5A5, 2'b00));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0,  0,  3, 3, 32'h22,       32'h22,       2'b00));
      tbl.push_back(mk(2'b01, 0, 32'h1234,     0, 32'h0,  1, 0,  0,  0, 0, 32'h0,        32'h0,        2'b00));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0,  0,  0, 0, 32'h0,        32'h0,        2'b00));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  1, 9,  0,  9, 0, 32'h0,        32'h0,        2'b00));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0,  0,  9, 9, 32'h0,        32'h0,        2'b11));
      tbl.push_back(mk(2'b01, 9, 32'hCAFE0009, 0, 32'h0,  0, 0,  0,  9, 3, 32'hCAFE0009, 32'h22,       2'b00));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0,  0,  9, 9, 32'hCAFE0009, 32'hCAFE0009, 2'b00));
      tbl.push_back(mk(2'b01, 9, 32'h99,       0, 32'h0,  1, 9,  0,  9, 5, 32'h99,       32'h0,        2'b00));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0,  0,  9, 9, 32'h99,       32'h99,       2'b11));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  1, 4,  1,  9, 4, 32'h99,       32'h0,        2'b01));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0,  0,  9, 4, 32'h99,       32'h0,        2'b00));
      tbl.push_back(mk(2'b11, 10, 32'hAAAA,   11, 32'hBBBB, 0, 0, 0, 10, 11, 32'hAAAA,   32'hBBBB,     2'b00));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  1, 12, 0, 10, 11, 32'hAAAA,   32'hBBBB,     2'b00));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0,  0, 12, 12, 32'h0,       32'h0,        2'b11));
      tbl.push_back(mk(2'b10, 0, 32'h0,       12, 32'h55, 0, 0,  0, 12, 10, 32'h55,      32'hAAAA,     2'b00));
      tbl.push_back(mk(2'b00, 0, 32'h0,        0, 32'h0,  0, 0,  0, 12, 12, 32'h55,      32'h55,       2'b00));

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         wr_en = tbl[k].we;
         wr_addr = {tbl[k].wa1, tbl[k].wa0};
         wr_data = {tbl[k].wd1, tbl[k].wd0};
         sb_set = tbl[k].set; sb_addr = tbl[k].sa; sb_flush = tbl[k].fl;
         rd_addr = {tbl[k].ra1, tbl[k].ra0};
         expect_val($sformatf("row%0d_d0", k), 0, tbl[k].ed0);
         expect_val($sformatf("row%0d_d1", k), 1, tbl[k].ed1);
         expect_val($sformatf("row%0d_busy", k), 2, {30'b0, tbl[k].eb});
         #2 check_all();
      end

      // no-bypass instance: old value in write cycle, new value afterwards; raw busy
      @(negedge clk) idle();
      b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 32'hA5A5A5A5; b_rd_addr = {5'd7, 5'd7};
      expect_val("nobyp_write_cycle", 3, 32'h0);
      #2 check_all();
      @(negedge clk) b_wr_en = 1'b0;
      expect_val("nobyp_next_cycle", 3, 32'hA5A5A5A5);
      #2 check_all();
      @(negedge clk) b_sb_set = 1'b1; b_sb_addr = 5'd6; b_rd_addr = {5'd7, 5'd6};
      expect_val("nobyp_busy_before", 4, 32'h0);
      #2 check_all();
      @(negedge clk) b_sb_set = 1'b0; b_wr_en = 1'b1; b_wr_addr = 5'd6; b_wr_data = 32'h66;
      expect_val("nobyp_busy_raw", 4, 32'h1);
      expect_val("nobyp_old6", 5, 32'h0);
      #2 check_all();
      @(negedge clk) b_wr_en = 1'b0;
      expect_val("nobyp_busy_clr", 4, 32'h0);
      expect_val("nobyp_new6", 5, 32'h66);
      #2 check_all();

      // asynchronous reset mid-cycle
      @(negedge clk) idle();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
      sb_set = 1'b1; sb_addr = 5'd5;
      @(negedge clk) idle();
      rd_addr = {5'd5, 5'd5};
      expect_val("pre_rst_d0", 0, 32'hDEADBEEF);
      expect_val("pre_rst_busy", 2, 32'h3);
      #2 check_all();
      #1 rst_n = 1'b0;
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hFFFF};
      #1;
      expect_val("async_rst_d0", 0, 32'h0);
      expect_val("async_rst_d1", 1, 32'h0);
      expect_val("async_rst_busy", 2, 32'h0);
      check_all();
      @(negedge clk) idle();
      rst_n = 1'b1;
      #2;
      expect_val("post_rst_d0", 0, 32'h0);
      expect_val("post_rst_busy", 2, 32'h0);
      check_all();
      @(negedge clk);
      expect_val("post_rel_d1", 1, 32'h0);
      expect_val("post_rel_busy", 2, 32'h0);
      #2 check_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_multiport_sb.md
Name: rf_multiport_sb

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Adds N read ports, M write ports, asynchronous reset clearing, optional write-to-read bypass, and a per-register busy scoreboard.
- The pipeline uses the scoreboard to detect RAW hazards on in-flight producers, e.g. loads and multi-cycle ops.
- Sits in the decode stage. Read ports feed operand latches; write ports are driven from writeback.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of architectural registers (power of two, >=2)
- ADDR_W, $clog2(DEPTH), register index width (derived, not overridable)
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read indices; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  scoreboard busy flag for each read index, combinational
- wr_en  in  NUM_WR  write enable per port
- wr_addr  in  NUM_WR*ADDR_W  write indices
- wr_data  in  NUM_WR*DATA_W  write data
- sb_set  in  1  mark sb_addr busy (producer issued)
- sb_addr  in  ADDR_W  register being claimed
- sb_flush  in  1  synchronous clear of all busy bits (pipeline flush)

Behaviour:
- Reset: rst_n low asynchronously clears all registers to 0 and all busy bits to 0.
  - While rst_n is low, rd_data = 0 and rd_busy = 0 for every port.
  - Deassertion takes effect on the next rising clk edge; no write occurs in the release cycle unless wr_en is high after release.
- Writes: on posedge clk, for each port j with wr_en[j] high, reg[wr_addr[j]] <= wr_data[j].
  - Two ports writing the same address in one cycle: highest-index port wins.
  - ZERO_REG=1: writes to index 0 are dropped.
- Reads, combinational, zero latency:
  - ZERO_REG=1 and rd_addr=0 -> 0.
  - Else if BYPASS=1 and some wr_en[j] with wr_addr[j]==rd_addr -> that wr_data. If several ports match, highest index wins.
  - Else stored value.
  - BYPASS=0: a read returns the old value in the write cycle and the new value from the next cycle.
- Scoreboard: one busy bit per register, updated on posedge clk.
  - Clear: every index written by an enabled write port has its busy bit cleared.
  - Set: sb_set sets busy[sb_addr].
  - Same index cleared and set in one cycle: set wins (newer producer).
  - sb_flush clears all bits and overrides sb_set in the same cycle.
  - ZERO_REG=1: busy[0] is constant 0.
- rd_busy[i] = busy[rd_addr[i]] AND NOT (BYPASS=1 and an enabled write to rd_addr[i] this cycle). The in-flight result is visible now, so no stall is requested.
  - BYPASS=0: rd_busy reflects the raw busy bit.
- No internal FSM beyond the storage and scoreboard state. All outputs are pure functions of state and current inputs.
- Out-of-range indices cannot occur because DEPTH is a power of two.
- Widths: no arithmetic. All comparisons are on exactly ADDR_W bits.

Decomposition:
- Shared package rf_pkg:
  - DATA_W/DEPTH defaults
  - function clog2 for ADDR_W
  - localparam REG_ZERO = 0
- One sub-module, rf_scoreboard: busy vector, set/clear/flush priority, and per-port rd_busy masking. Instantiated once.
- Storage and bypass muxing stay in the top module, generated over NUM_RD/NUM_WR.

Test Plan:
- Reset: preload reg5=32'hDEADBEEF, set busy[5]; pulse rst_n low mid-cycle -> immediately rd_data(addr5)=0, rd_busy=0, with no clk edge needed.
- Zero register: write 32'h1234 to index 0 and sb_set addr0 -> rd_data(addr0)=0, rd_busy=0 on all subsequent cycles.
- Bypass: BYPASS=1, wr_en=1, addr 7, data 32'hA5A5A5A5; read port1 addr7 in the same cycle -> 32'hA5A5A5A5. BYPASS=0 instance -> old value 0 that cycle, A5A5A5A5 next cycle.
- Dual-write conflict: NUM_WR=2, both ports write addr 3 with 32'h11 and 32'h22 -> reg3=32'h22 next cycle; same-cycle bypass read also returns 32'h22.
- Scoreboard lifecycle: sb_set addr 9 -> next cycle rd_busy=1 for addr9. Then write addr9 with BYPASS=1 -> rd_busy=0 during the write cycle, busy bit cleared after it.
- Set/clear collision and flush:
  - Write addr9 while sb_set addr9 -> busy stays 1.
  - sb_flush together with sb_set addr4 -> all busy bits 0 next cycle.
